// File: rtl/pwm_panel_driver_if.sv
// pwm_panel_driver_if: host-side write and bank-swap bus of pwm_panel_driver.
// Signals:
//   wr_en/wr_chan/wr_addr/wr_data  write one intensity value into the back bank
//   swap_req                       request a front/back swap at the next frame boundary
//   swap_ack                       one-cycle pulse when the swap is performed
//   front_bank                     index of the bank currently displayed
// Modports: master = host, slave = driver.
interface pwm_panel_driver_if #(
    parameter int NUM_CHANNELS = 3,
    parameter int NUM_LEDS     = 16,
    parameter int VAL_W        = 8
);
    localparam int ADDR_W = $clog2(NUM_LEDS);
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic              wr_en;
    logic [CHAN_W-1:0] wr_chan;
    logic [ADDR_W-1:0] wr_addr;
    logic [VAL_W-1:0]  wr_data;
    logic              swap_req;
    logic              swap_ack;
    logic              front_bank;

    modport master (
        output wr_en, wr_chan, wr_addr, wr_data, swap_req,
        input  swap_ack, front_bank
    );

    modport slave (
        input  wr_en, wr_chan, wr_addr, wr_data, swap_req,
        output swap_ack, front_bank
    );
endinterface

// File: rtl/pwm_panel_driver.sv
// pwm_panel_driver: double-buffered per-LED/per-channel intensity frame, PWM time
// base and serialiser feeding NUM_CHANNELS panel shift chains.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             run PWM slices while high (a started slice always completes)
//   bus                host write / swap bus (slave side)
//   serial_data_out    one compare bit per chain, valid while shift is high
//   shift, latch       panel shift and output-latch strobes
//   frame_done         pulse with the last latch of a PWM frame
module pwm_panel_driver #(
    parameter int NUM_CHANNELS = 3,
    parameter int NUM_LEDS     = 16,
    parameter int VAL_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    pwm_panel_driver_if.slave       bus,
    output logic [NUM_CHANNELS-1:0] serial_data_out,
    output logic                    shift,
    output logic                    latch,
    output logic                    frame_done
);
    localparam int ADDR_W = $clog2(NUM_LEDS);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]        pwm_time_q, pwm_time_d;
    logic                    front_q, front_d;
    logic                    pend_q, pend_d;
    logic [NUM_CHANNELS-1:0] sdo_q, sdo_d;
    logic                    shift_q, shift_d;
    logic                    latch_q, latch_d;
    logic                    done_q, done_d;
    logic                    ack_q, ack_d;
    logic [VAL_W-1:0]        mem_q [2][NUM_CHANNELS][NUM_LEDS];
    logic [VAL_W-1:0]        mem_d [2][NUM_CHANNELS][NUM_LEDS];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pwm_time_d = pwm_time_q;
        front_d    = front_q;
        pend_d     = pend_q | bus.swap_req;
        sdo_d      = '0;
        shift_d    = 1'b0;
        latch_d    = 1'b0;
        done_d     = 1'b0;
        ack_d      = 1'b0;
        mem_d      = mem_q;
        // Writes go to the back bank as seen before this edge.
        if (bus.wr_en && (int'(bus.wr_chan) < NUM_CHANNELS) && (int'(bus.wr_addr) < NUM_LEDS))
            mem_d[~front_q][bus.wr_chan][bus.wr_addr] = bus.wr_data;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    idx_d   = ADDR_W'(NUM_LEDS - 1);
                end
            end
            SHIFT: begin
                shift_d = 1'b1;
                for (int c = 0; c < NUM_CHANNELS; c++)
                    sdo_d[c] = mem_q[front_q][c][idx_q] > pwm_time_q;
                idx_d   = idx_q - 1'b1;
                state_d = (idx_q == '0) ? LATCH : SHIFT;
            end
            LATCH: begin
                latch_d    = 1'b1;
                pwm_time_d = pwm_time_q + 1'b1;
                idx_d      = ADDR_W'(NUM_LEDS - 1);
                state_d    = enable ? SHIFT : IDLE;
                // Frame boundary: the only point where the displayed bank may change.
                if (&pwm_time_q) begin
                    done_d = 1'b1;
                    if (pend_d) begin
                        front_d = ~front_q;
                        pend_d  = 1'b0;
                        ack_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pwm_time_q <= '0;
            front_q    <= 1'b0;
            pend_q     <= 1'b0;
            sdo_q      <= '0;
            shift_q    <= 1'b0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pwm_time_q <= pwm_time_d;
            front_q    <= front_d;
            pend_q     <= pend_d;
            sdo_q      <= sdo_d;
            shift_q    <= shift_d;
            latch_q    <= latch_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            mem_q      <= mem_d;
        end
    end

    assign serial_data_out = sdo_q;
    assign shift           = shift_q;
    assign latch           = latch_q;
    assign frame_done      = done_q;
    assign bus.swap_ack    = ack_q;
    assign bus.front_bank  = front_q;
endmodule

// File: doc/pwm_panel_driver.md
Name: pwm_panel_driver

Overview:
Parametrised successor to the fixed-colour panel driver. Holds a double-buffered frame of per-LED, per-channel intensity values written by the host. Runs its own PWM time base and serialises one comparison bit per LED per channel into NUM_CHANNELS serial chains. Emits shift/latch strobes for the panel shift registers. Sits between the host register interface and the panel output pins.

Parameters:
NUM_CHANNELS, 3, number of colour components / serial chains
NUM_LEDS, 16, LEDs per chain (shift length per PWM slice), >=2
VAL_W, 8, intensity width; PWM period = 2^VAL_W slices
ADDR_W, $clog2(NUM_LEDS), LED index width (derived)
CHAN_W, $clog2(NUM_CHANNELS) (min 1), channel index width (derived)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run PWM/serialisation while high
wr_en  in  1  write strobe into back bank
wr_chan  in  CHAN_W  channel index of write
wr_addr  in  ADDR_W  LED index of write
wr_data  in  VAL_W  intensity value
swap_req  in  1  request back/front bank swap at next frame boundary
serial_data_out  out  NUM_CHANNELS  serial data, one bit per chain
shift  out  1  data valid / shift strobe for panel
latch  out  1  panel output-latch strobe
frame_done  out  1  one-cycle pulse on last latch of a PWM frame
swap_ack  out  1  one-cycle pulse when a swap is performed
front_bank  out  1  index of bank currently displayed

Behaviour:
- Reset (async, reset_n=0): all outputs 0; both banks cleared to 0; pwm_time=0; front_bank=0; swap pending cleared; FSM to IDLE. Outputs drop without waiting for clk.
- Storage: 2 banks x NUM_CHANNELS x NUM_LEDS x VAL_W. Writes always target bank !front_bank. The pointer sampled is the pre-edge value, so a write on the swap edge lands in the bank that becomes front.
- Out-of-range writes (wr_chan>=NUM_CHANNELS or wr_addr>=NUM_LEDS) are ignored.
- FSM states: IDLE, SHIFT, LATCH.
  - IDLE -> SHIFT when enable=1. idx loads NUM_LEDS-1.
  - SHIFT: idx decrements each cycle; after idx=0 -> LATCH.
  - LATCH -> SHIFT if enable=1, else IDLE.
- Outputs are registered, one cycle behind the state:
  - Per SHIFT cycle with index k: next cycle shift=1 and serial_data_out[c] = (front[c][k] > pwm_time), unsigned compare.
  - Per LATCH cycle: next cycle latch=1, shift=0.
- Ordering: LED NUM_LEDS-1 is shifted first, LED 0 last.
- Steady-state slice period: NUM_LEDS+1 cycles, with shift high for NUM_LEDS consecutive cycles followed by latch high for 1 cycle.
- Value 0 is always off; value 2^VAL_W-1 is on for 2^VAL_W-1 of 2^VAL_W slices.
- pwm_time increments at each LATCH state and wraps from 2^VAL_W-1 to 0.
- Frame boundary (LATCH with pwm_time=2^VAL_W-1):
  - frame_done=1 coincident with latch.
  - If swap pending (including a swap_req sampled at that same edge): front_bank toggles, pending clears, swap_ack=1 coincident with latch.
  - The next slice uses the new front bank with pwm_time=0.
- Multiple swap_req pulses within one frame collapse into a single swap.
- enable deasserted mid-slice: the current slice completes (remaining shifts plus latch), then IDLE. pwm_time holds its incremented value. Re-enable resumes at that pwm_time with no output glitch.
- The compare uses front values read at the SHIFT cycle. A bank swap can only occur at LATCH, so a slice never mixes banks.

Test Plan:
1. Reset mid-SHIFT (NUM_LEDS=4, VAL_W=4) with reset_n low -> shift, latch, serial_data_out, frame_done and swap_ack all 0 before the next clk edge; after release with enable=0, outputs stay 0 indefinitely.
2. Write ch0 LED3=5 and ch2 LED0=15, pulse swap_req, enable=1 -> first frame all zeros; frame_done and swap_ack on the 16th latch; front_bank=1. Next frame: serial_data_out[0]=1 on the first shift cycle of slices 0..4 and 0 for slices 5..15. serial_data_out[2]=1 on the 4th shift cycle of slices 0..14 and 0 in slice 15.
3. Period check -> shift high exactly 4 consecutive cycles then latch 1 cycle; frame = 80 cycles; frame_done exactly once per 80 cycles.
4. Write LED1=9 mid-frame and assert swap_req 3 times in the frame -> value not displayed until after the boundary; exactly one swap_ack; front_bank toggles once.
5. Drop enable during the 2nd shift of slice 6 -> 2 more shifts and 1 latch, then idle with no strobes. Re-enable -> the next slice compares against pwm_time=7.
6. Out-of-range write (wr_chan=3 with NUM_CHANNELS=3) then swap -> all displayed values unchanged; swap_req on the boundary-latch edge -> honoured in that same cycle (swap_ack=1).
